collision_scanner: RTL and testbench
====================================

Name: collision_scanner

Overview:
- Upstream sequencer for the point-vs-segment collision stage.
- For one mass point's proposed move, walks the obstacle edge list stored in a local edge RAM and issues one request per edge to the collision stage.
- Takes the first edge that reports a collision and returns the corrected position/velocity; with no hit, returns the unobstructed move.
- Sits between the soft-body integrator (requester) and the collision stage.

Parameters:
- POSITION_SIZE, 8, signed position/displacement width.
- VELOCITY_SIZE, 8, signed velocity width.
- MAX_EDGES, 16, edge RAM depth.
- IDX_W, $clog2(MAX_EDGES), edge index width.
- TIMEOUT, 255, max cycles waiting on one collision-stage response.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset, synchronous, active-low
- edge_we_in  in  1  edge RAM write strobe
- edge_addr_in  in  IDX_W  edge write address
- edge_v1_in  in  2x POSITION_SIZE  edge start {x,y}, signed
- edge_v2_in  in  2x POSITION_SIZE  edge end {x,y}, signed
- num_edges_in  in  IDX_W+1  active edge count, sampled at start
- start_in  in  1  request strobe
- pos_x_in, pos_y_in  in  POSITION_SIZE  current point position
- vel_x_in, vel_y_in  in  VELOCITY_SIZE  current velocity
- dx_in, dy_in  in  POSITION_SIZE  proposed displacement
- busy_out  out  1  high from accepted start until the output_valid cycle, inclusive
- coll_valid_out  out  1  one-cycle request pulse to the collision stage
- coll_v1_out, coll_v2_out  out  2x POSITION_SIZE  edge to the collision stage
- coll_pos_x_out, coll_pos_y_out, coll_vel_x_out, coll_vel_y_out, coll_dx_out, coll_dy_out  out  as inputs  latched request, held stable while busy
- coll_valid_in  in  1  collision-stage result strobe
- coll_collision_in  in  1  collision flag with the result
- coll_x_new_in, coll_y_new_in  in  POSITION_SIZE  corrected position
- coll_vx_new_in, coll_vy_new_in  in  VELOCITY_SIZE  corrected velocity
- x_new_out, y_new_out  out  POSITION_SIZE  final position
- vx_new_out, vy_new_out  out  VELOCITY_SIZE  final velocity
- collision_out  out  1  a hit occurred
- edge_idx_out  out  IDX_W  index of the hit edge (0 if none)
- timeout_out  out  1  at least one edge timed out during this request
- output_valid  out  1  one-cycle result pulse

Behaviour:
- Reset (rst_in low at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including busy_out, coll_valid_out and output_valid.
  - Edge RAM contents are not cleared.
  - Reset mid-scan abandons the scan. coll_valid_in arriving later while in IDLE is ignored.
- Edge RAM:
  - Synchronous write, synchronous read with 1-cycle latency.
  - Writes are accepted only when busy_out is 0 and are silently dropped while busy.
- States: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE:
  - On start_in, latch every request input and num_edges, clamped to MAX_EDGES. Set idx=0 and timeout_out=0.
  - Go to DONE if the clamped count is 0, otherwise FETCH. busy_out rises the next cycle.
  - start_in while busy is ignored.
- FETCH: present idx to the RAM, then go to ISSUE.
- ISSUE: register the RAM data onto coll_v1_out/coll_v2_out, pulse coll_valid_out for exactly this cycle, clear the wait counter, then go to WAIT.
- WAIT:
  - On coll_valid_in with coll_collision_in=1: capture the coll_*_new_in values, set collision_out=1 and edge_idx_out=idx, go to DONE.
  - On coll_valid_in with coll_collision_in=0, or when the wait counter reaches TIMEOUT (which also sets timeout_out=1): if idx == count-1, go to DONE with no hit; else idx++ and go to FETCH.
  - A coll_valid_in in the same cycle as the timeout takes priority over the timeout.
- DONE:
  - output_valid=1 for this one cycle, then go to IDLE. busy_out falls the following cycle.
  - No hit: x_new_out=pos_x+dx and y_new_out=pos_y+dy, each truncated to POSITION_SIZE with two's-complement wrap. Velocity passes through unchanged, collision_out=0, edge_idx_out=0.
  - Result outputs hold until the next DONE.
- Priority: the lowest-index colliding edge wins; later edges are not issued.
- Latency:
  - Zero edges: start sampled at edge k gives output_valid in cycle k+1.
  - Per edge: 2 cycles plus the collision-stage latency plus 1.

Decomposition:
- Package collision_pkg: scan_state_t enum, a vertex struct {x,y} sized by POSITION_SIZE, and the TIMEOUT default.
- Sub-module edge_ram (MAX_EDGES x 4*POSITION_SIZE, 1W/1R, synchronous read). The FSM stays in collision_scanner.

Test Plan:
- Zero edges: num_edges=0, pos=(10,20), dx=-3, dy=5, vel=(1,2) -> output_valid in cycle k+1, new=(7,25), vel=(1,2), collision_out=0.
- Hit on edge 2 of 4:
  - Setup: edges loaded; model returns collision=0 for idx 0,1 and collision=1 with new=(4,-6), vel=(-3,9) for idx 2.
  - Response: exactly 3 coll_valid_out pulses, edge_idx_out=2, outputs equal the captured values.
- No hit, 16 edges, wrap:
  - Setup: model always returns 0; pos=(120,0), dx=20.
  - Response: 16 requests, x_new_out=-116, collision_out=0.
- Timeout: model never answers for idx 0 and answers 0 for idx 1 -> timeout_out=1 after 255 wait cycles, then idx 1 is issued and the final result has no hit.
- Busy rules:
  - edge_we_in during a scan -> RAM unchanged, verified by a subsequent scan.
  - start_in during a scan -> ignored, exactly one output_valid.
- Reset mid-WAIT: rst_in low one cycle, then a late coll_valid_in -> no output_valid, busy_out=0, all outputs 0.

Source files
------------

// File: rtl/collision_pkg.sv
// collision_pkg: shared types and defaults for the collision scanner slice.
//   scan_state_t : scanner FSM state encoding
//   vertex_t     : one signed {x,y} edge endpoint at the default position width
//   DEF_*        : default parameter values for collision_scanner
package collision_pkg;

    localparam int DEF_POSITION_SIZE = 8;
    localparam int DEF_VELOCITY_SIZE = 8;
    localparam int DEF_MAX_EDGES     = 16;
    localparam int DEF_TIMEOUT       = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_t;

    typedef struct packed {
        logic signed [DEF_POSITION_SIZE-1:0] x;
        logic signed [DEF_POSITION_SIZE-1:0] y;
    } vertex_t;

endpackage

// File: rtl/edge_ram.sv
// edge_ram: obstacle edge store, one write port and one read port.
//   clk_in, rst_in : clock, synchronous active-low reset (read register only)
//   we, waddr, wdata : synchronous write
//   re, raddr       : read request; data appears on rdata one cycle later
//   rdata           : registered read data, held until the next read
// Memory contents are never cleared by reset; only the read register is.
module edge_ram #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/collision_scanner.sv
// collision_scanner: walks the stored obstacle edges for one proposed point
// move, issuing one request per edge to the collision stage, and returns the
// first hit's corrected state or the unobstructed move.
//   clk_in, rst_in       : clock, synchronous active-low reset
//   edge_*_in            : edge RAM write port (ignored while busy)
//   num_edges_in         : active edge count, sampled with start_in
//   start_in, pos/vel/d* : request strobe and request data
//   busy_out             : accepted start through the output_valid cycle
//   coll_*_out           : request to the collision stage
//   coll_*_in            : response from the collision stage
//   *_new_out, collision_out, edge_idx_out, timeout_out, output_valid : result
//   state_out            : current FSM state, for observation
//
// Collision-stage handshake: coll_valid_out is a one-cycle pulse with no
// back-pressure; coll_v1/v2_out and the coll_pos/vel/d outputs are stable for
// the whole request. The stage answers with a single coll_valid_in pulse any
// time after that; only answers arriving in WAIT are used, everything else is
// dropped. An edge with no answer after TIMEOUT wait cycles counts as no hit.
module collision_scanner
    import collision_pkg::*;
#(
    parameter int POSITION_SIZE = DEF_POSITION_SIZE,
    parameter int VELOCITY_SIZE = DEF_VELOCITY_SIZE,
    parameter int MAX_EDGES     = DEF_MAX_EDGES,
    parameter int IDX_W         = $clog2(MAX_EDGES),
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            edge_we_in,
    input  logic [IDX_W-1:0]                edge_addr_in,
    input  logic [2*POSITION_SIZE-1:0]      edge_v1_in,
    input  logic [2*POSITION_SIZE-1:0]      edge_v2_in,
    input  logic [IDX_W:0]                  num_edges_in,
    input  logic                            start_in,
    input  logic signed [POSITION_SIZE-1:0] pos_x_in,
    input  logic signed [POSITION_SIZE-1:0] pos_y_in,
    input  logic signed [VELOCITY_SIZE-1:0] vel_x_in,
    input  logic signed [VELOCITY_SIZE-1:0] vel_y_in,
    input  logic signed [POSITION_SIZE-1:0] dx_in,
    input  logic signed [POSITION_SIZE-1:0] dy_in,
    output logic                            busy_out,
    output logic                            coll_valid_out,
    output logic [2*POSITION_SIZE-1:0]      coll_v1_out,
    output logic [2*POSITION_SIZE-1:0]      coll_v2_out,
    output logic signed [POSITION_SIZE-1:0] coll_pos_x_out,
    output logic signed [POSITION_SIZE-1:0] coll_pos_y_out,
    output logic signed [VELOCITY_SIZE-1:0] coll_vel_x_out,
    output logic signed [VELOCITY_SIZE-1:0] coll_vel_y_out,
    output logic signed [POSITION_SIZE-1:0] coll_dx_out,
    output logic signed [POSITION_SIZE-1:0] coll_dy_out,
    input  logic                            coll_valid_in,
    input  logic                            coll_collision_in,
    input  logic signed [POSITION_SIZE-1:0] coll_x_new_in,
    input  logic signed [POSITION_SIZE-1:0] coll_y_new_in,
    input  logic signed [VELOCITY_SIZE-1:0] coll_vx_new_in,
    input  logic signed [VELOCITY_SIZE-1:0] coll_vy_new_in,
    output logic signed [POSITION_SIZE-1:0] x_new_out,
    output logic signed [POSITION_SIZE-1:0] y_new_out,
    output logic signed [VELOCITY_SIZE-1:0] vx_new_out,
    output logic signed [VELOCITY_SIZE-1:0] vy_new_out,
    output logic                            collision_out,
    output logic [IDX_W-1:0]                edge_idx_out,
    output logic                            timeout_out,
    output logic                            output_valid,
    output scan_state_t                     state_out
);

    localparam int CNT_W  = IDX_W + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int EDGE_W = 4 * POSITION_SIZE;

    scan_state_t       state, next_state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  clamped_count;
    logic [WAIT_W-1:0] wait_cnt;
    logic              last_edge;
    logic              wait_expired;
    logic              hit;
    logic              step_no_hit;
    logic [EDGE_W-1:0] ram_rdata;

    // The RAM read register is the edge presented to the collision stage:
    // it is loaded only in FETCH, so it holds for the whole request.
    edge_ram #(
        .DEPTH  (MAX_EDGES),
        .WIDTH  (EDGE_W),
        .ADDR_W (IDX_W)
    ) u_edge_ram (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .we     (edge_we_in && (state == ST_IDLE)),
        .waddr  (edge_addr_in),
        .wdata  ({edge_v1_in, edge_v2_in}),
        .re     (state == ST_FETCH),
        .raddr  (idx),
        .rdata  (ram_rdata)
    );

    assign coll_v1_out = ram_rdata[EDGE_W-1 -: 2*POSITION_SIZE];
    assign coll_v2_out = ram_rdata[2*POSITION_SIZE-1:0];

    assign clamped_count = (num_edges_in > CNT_W'(MAX_EDGES)) ? CNT_W'(MAX_EDGES)
                                                              : num_edges_in;
    assign last_edge     = ({1'b0, idx} == (count - CNT_W'(1)));
    assign wait_expired  = (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign hit           = (state == ST_WAIT) && coll_valid_in && coll_collision_in;
    // A response in the timeout cycle wins over the timeout.
    assign step_no_hit   = (state == ST_WAIT) &&
                           (coll_valid_in ? !coll_collision_in : wait_expired);

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start_in) next_state = (clamped_count == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH: next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT: begin
                if (hit) begin
                    next_state = ST_DONE;
                end else if (step_no_hit) begin
                    next_state = last_edge ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy_out       = (state != ST_IDLE);
        coll_valid_out = (state == ST_ISSUE);
        output_valid   = (state == ST_DONE);
        state_out      = state;
    end

    // Datapath: request latch, scan counters and result registers.
    // Results are only written on the way into DONE, so they hold between runs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            idx            <= '0;
            count          <= '0;
            wait_cnt       <= '0;
            coll_pos_x_out <= '0;
            coll_pos_y_out <= '0;
            coll_vel_x_out <= '0;
            coll_vel_y_out <= '0;
            coll_dx_out    <= '0;
            coll_dy_out    <= '0;
            x_new_out      <= '0;
            y_new_out      <= '0;
            vx_new_out     <= '0;
            vy_new_out     <= '0;
            collision_out  <= 1'b0;
            edge_idx_out   <= '0;
            timeout_out    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        coll_pos_x_out <= pos_x_in;
                        coll_pos_y_out <= pos_y_in;
                        coll_vel_x_out <= vel_x_in;
                        coll_vel_y_out <= vel_y_in;
                        coll_dx_out    <= dx_in;
                        coll_dy_out    <= dy_in;
                        count          <= clamped_count;
                        idx            <= '0;
                        timeout_out    <= 1'b0;
                        // No edges: DONE is next, so the free move is formed
                        // straight from the inputs (sum wraps at POSITION_SIZE).
                        if (clamped_count == '0) begin
                            x_new_out     <= pos_x_in + dx_in;
                            y_new_out     <= pos_y_in + dy_in;
                            vx_new_out    <= vel_x_in;
                            vy_new_out    <= vel_y_in;
                            collision_out <= 1'b0;
                            edge_idx_out  <= '0;
                        end
                    end
                end
                ST_ISSUE: wait_cnt <= '0;
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                    if (!coll_valid_in && wait_expired) begin
                        timeout_out <= 1'b1;
                    end
                    if (hit) begin
                        x_new_out     <= coll_x_new_in;
                        y_new_out     <= coll_y_new_in;
                        vx_new_out    <= coll_vx_new_in;
                        vy_new_out    <= coll_vy_new_in;
                        collision_out <= 1'b1;
                        edge_idx_out  <= idx;
                    end else if (step_no_hit) begin
                        if (last_edge) begin
                            x_new_out     <= coll_pos_x_out + coll_dx_out;
                            y_new_out     <= coll_pos_y_out + coll_dy_out;
                            vx_new_out    <= coll_vel_x_out;
                            vy_new_out    <= coll_vel_y_out;
                            collision_out <= 1'b0;
                            edge_idx_out  <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collision_scanner.sv
module tb_collision_scanner;
  import collision_pkg::*;

  localparam int P  = 8;
  localparam int V  = 8;
  localparam int ME = 16;
  localparam int IW = 4;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic              edge_we_in = 1'b0;
  logic [IW-1:0]     edge_addr_in = '0;
  logic [2*P-1:0]    edge_v1_in = '0, edge_v2_in = '0;
  logic [IW:0]       num_edges_in = '0;
  logic              start_in = 1'b0;
  logic signed [P-1:0] pos_x_in = '0, pos_y_in = '0, dx_in = '0, dy_in = '0;
  logic signed [V-1:0] vel_x_in = '0, vel_y_in = '0;
  logic              busy_out, coll_valid_out;
  logic [2*P-1:0]    coll_v1_out, coll_v2_out;
  logic signed [P-1:0] coll_pos_x_out, coll_pos_y_out, coll_dx_out, coll_dy_out;
  logic signed [V-1:0] coll_vel_x_out, coll_vel_y_out;
  logic              coll_valid_in = 1'b0, coll_collision_in = 1'b0;
  logic signed [P-1:0] coll_x_new_in = '0, coll_y_new_in = '0;
  logic signed [V-1:0] coll_vx_new_in = '0, coll_vy_new_in = '0;
  logic signed [P-1:0] x_new_out, y_new_out;
  logic signed [V-1:0] vx_new_out, vy_new_out;
  logic              collision_out, timeout_out, output_valid;
  logic [IW-1:0]     edge_idx_out;
  scan_state_t       state_out;

  collision_scanner dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .edge_we_in(edge_we_in), .edge_addr_in(edge_addr_in),
    .edge_v1_in(edge_v1_in), .edge_v2_in(edge_v2_in),
    .num_edges_in(num_edges_in), .start_in(start_in),
    .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
    .vel_x_in(vel_x_in), .vel_y_in(vel_y_in),
    .dx_in(dx_in), .dy_in(dy_in),
    .busy_out(busy_out), .coll_valid_out(coll_valid_out),
    .coll_v1_out(coll_v1_out), .coll_v2_out(coll_v2_out),
    .coll_pos_x_out(coll_pos_x_out), .coll_pos_y_out(coll_pos_y_out),
    .coll_vel_x_out(coll_vel_x_out), .coll_vel_y_out(coll_vel_y_out),
    .coll_dx_out(coll_dx_out), .coll_dy_out(coll_dy_out),
    .coll_valid_in(coll_valid_in), .coll_collision_in(coll_collision_in),
    .coll_x_new_in(coll_x_new_in), .coll_y_new_in(coll_y_new_in),
    .coll_vx_new_in(coll_vx_new_in), .coll_vy_new_in(coll_vy_new_in),
    .x_new_out(x_new_out), .y_new_out(y_new_out),
    .vx_new_out(vx_new_out), .vy_new_out(vy_new_out),
    .collision_out(collision_out), .edge_idx_out(edge_idx_out),
    .timeout_out(timeout_out), .output_valid(output_valid),
    .state_out(state_out)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // ---------------- reference edge store ----------------
  logic [4*P-1:0] edge_model [ME];

  function automatic logic [4*P-1:0] edge_val(input int i);
    vertex_t a, b;
    a.x = 8'(i * 5);
    a.y = 8'(-i);
    b.x = 8'(i + 40);
    b.y = 8'(i * 9 - 7);
    return {a, b};
  endfunction

  // ---------------- collision-stage model ----------------
  // mode: 0 = answer no hit, 1 = answer hit, 2 = never answer
  int mode [ME];
  int pulses = 0;
  int pend = 0;
  int cdown = -1;
  int pulse_cyc [ME+4];
  logic [4*P-1:0] obs_edge [ME+4];

  always @(negedge clk_in) begin
    coll_valid_in     = 1'b0;
    coll_collision_in = 1'b0;
    coll_x_new_in     = 8'sh55;
    coll_y_new_in     = 8'sh55;
    coll_vx_new_in    = 8'sh55;
    coll_vy_new_in    = 8'sh55;
    if (cdown == 0) begin
      coll_valid_in = 1'b1;
      if (mode[pend] == 1) begin
        coll_collision_in = 1'b1;
        coll_x_new_in     = 8'(4);
        coll_y_new_in     = 8'(-6);
        coll_vx_new_in    = 8'(-3);
        coll_vy_new_in    = 8'(9);
      end
      cdown = -1;
    end else if (cdown > 0) begin
      cdown--;
    end
    if (coll_valid_out === 1'b1) begin
      if (pulses < ME + 4) begin
        obs_edge[pulses]  = {coll_v1_out, coll_v2_out};
        pulse_cyc[pulses] = cyc;
      end
      pend   = pulses;
      pulses = pulses + 1;
      cdown  = (pend < ME && mode[pend] != 2) ? 1 : -1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_edge(input int addr, input logic [4*P-1:0] val);
    @(negedge clk_in);
    edge_we_in   = 1'b1;
    edge_addr_in = IW'(addr);
    {edge_v1_in, edge_v2_in} = val;
    @(negedge clk_in);
    edge_we_in = 1'b0;
    edge_model[addr] = val;
  endtask

  task automatic start_scan(input int ne, input int px, input int py, input int vx,
                            input int vy, input int dx, input int dy);
    @(negedge clk_in);
    num_edges_in = 5'(ne);
    pos_x_in = 8'(px);
    pos_y_in = 8'(py);
    vel_x_in = 8'(vx);
    vel_y_in = 8'(vy);
    dx_in    = 8'(dx);
    dy_in    = 8'(dy);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (output_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    cmp_cnt++; if (busy_out !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    cmp_cnt++; if (output_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_ov: got %b want 0", output_valid); end
    cmp_cnt++; if (coll_valid_out !== 1'b0) begin err_cnt++; $display("FAIL reset_cv: got %b want 0", coll_valid_out); end
    cmp_cnt++; if ({x_new_out, y_new_out, collision_out, timeout_out} !== '0) begin err_cnt++; $display("FAIL reset_result: got x=%0d y=%0d c=%b t=%b want all 0", x_new_out, y_new_out, collision_out, timeout_out); end
    cmp_cnt++; if (state_out !== ST_IDLE) begin err_cnt++; $display("FAIL reset_state: got %0d want %0d", state_out, ST_IDLE); end
    rst_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_zero_edges();
    start_scan(0, 10, 20, 1, 2, -3, 5);
    // start sampled at edge k; this negedge is in cycle k+1
    cmp_cnt++; if (output_valid !== 1'b1) begin err_cnt++; $display("FAIL zero_latency: got ov=%b want 1", output_valid); end
    cmp_cnt++; if (busy_out !== 1'b1) begin err_cnt++; $display("FAIL zero_busy: got %b want 1", busy_out); end
    cmp_cnt++; if (x_new_out !== 8'(7) || y_new_out !== 8'(25)) begin err_cnt++; $display("FAIL zero_pos: got (%0d,%0d) want (7,25)", x_new_out, y_new_out); end
    cmp_cnt++; if (vx_new_out !== 8'(1) || vy_new_out !== 8'(2)) begin err_cnt++; $display("FAIL zero_vel: got (%0d,%0d) want (1,2)", vx_new_out, vy_new_out); end
    cmp_cnt++; if (collision_out !== 1'b0 || edge_idx_out !== '0) begin err_cnt++; $display("FAIL zero_flags: got c=%b idx=%0d want 0,0", collision_out, edge_idx_out); end
    cmp_cnt++; if (pulses !== 0) begin err_cnt++; $display("FAIL zero_requests: got %0d want 0", pulses); end
    @(negedge clk_in);
    cmp_cnt++; if (output_valid !== 1'b0 || busy_out !== 1'b0) begin err_cnt++; $display("FAIL zero_after: got ov=%b busy=%b want 0,0", output_valid, busy_out); end
  endtask

  task automatic test_hit();
    bit ok;
    for (int i = 0; i < 4; i++) write_edge(i, edge_val(i));
    for (int i = 0; i < ME; i++) mode[i] = 0;
    mode[2] = 1;
    pulses = 0;
    start_scan(4, 10, 10, 1, 1, 2, 2);
    wait_done(200, ok);
    cmp_cnt++; if (!ok) begin err_cnt++; $display("FAIL hit_done: got no output_valid want one within 200 cycles"); end
    cmp_cnt++; if (collision_out !== 1'b1 || edge_idx_out !== 4'd2) begin err_cnt++; $display("FAIL hit_flags: got c=%b idx=%0d want 1,2", collision_out, edge_idx_out); end
    cmp_cnt++; if (x_new_out !== 8'(4) || y_new_out !== 8'(-6)) begin err_cnt++; $display("FAIL hit_pos: got (%0d,%0d) want (4,-6)", x_new_out, y_new_out); end
    cmp_cnt++; if (vx_new_out !== 8'(-3) || vy_new_out !== 8'(9)) begin err_cnt++; $display("FAIL hit_vel: got (%0d,%0d) want (-3,9)", vx_new_out, vy_new_out); end
    cmp_cnt++; if (timeout_out !== 1'b0) begin err_cnt++; $display("FAIL hit_timeout: got %b want 0", timeout_out); end
    cmp_cnt++; if (coll_pos_x_out !== 8'(10) || coll_dx_out !== 8'(2) || coll_vel_y_out !== 8'(1)) begin err_cnt++; $display("FAIL hit_req_hold: got px=%0d dx=%0d vy=%0d want 10,2,1", coll_pos_x_out, coll_dx_out, coll_vel_y_out); end
    for (int i = 0; i < 3; i++) begin
      cmp_cnt++; if (obs_edge[i] !== edge_model[i]) begin err_cnt++; $display("FAIL hit_edge%0d: got %h want %h", i, obs_edge[i], edge_model[i]); end
    end
    repeat (4) @(negedge clk_in);
    cmp_cnt++; if (pulses !== 3) begin err_cnt++; $display("FAIL hit_requests: got %0d want 3", pulses); end
  endtask

  task automatic test_wrap_16();
    bit ok;
    for (int i = 0; i < ME; i++) write_edge(i, edge_val(i + 3));
    for (int i = 0; i < ME; i++) mode[i] = 0;
    pulses = 0;
    // 20 edges requested: count clamps to 16
    start_scan(20, 120, 0, 5, -7, 20, 0);
    wait_done(400, ok);
    cmp_cnt++; if (!ok) begin err_cnt++; $display("FAIL wrap_done: got no output_valid want one within 400 cycles"); end
    cmp_cnt++; if (x_new_out !== 8'(-116) || y_new_out !== 8'(0)) begin err_cnt++; $display("FAIL wrap_pos: got (%0d,%0d) want (-116,0)", x_new_out, y_new_out); end
    cmp_cnt++; if (vx_new_out !== 8'(5) || vy_new_out !== 8'(-7)) begin err_cnt++; $display("FAIL wrap_vel: got (%0d,%0d) want (5,-7)", vx_new_out, vy_new_out); end
    cmp_cnt++; if (collision_out !== 1'b0 || edge_idx_out !== '0 || timeout_out !== 1'b0) begin err_cnt++; $display("FAIL wrap_flags: got c=%b idx=%0d t=%b want 0,0,0", collision_out, edge_idx_out, timeout_out); end
    cmp_cnt++; if (obs_edge[15] !== edge_model[15]) begin err_cnt++; $display("FAIL wrap_edge15: got %h want %h", obs_edge[15], edge_model[15]); end
    repeat (4) @(negedge clk_in);
    cmp_cnt++; if (pulses !== 16) begin err_cnt++; $display("FAIL wrap_requests: got %0d want 16", pulses); end
  endtask

  task automatic test_timeout();
    bit ok;
    for (int i = 0; i < ME; i++) mode[i] = 0;
    mode[0] = 2;
    pulses = 0;
    start_scan(2, -5, 3, 2, 2, 1, -1);
    wait_done(1000, ok);
    cmp_cnt++; if (!ok) begin err_cnt++; $display("FAIL to_done: got no output_valid want one within 1000 cycles"); end
    cmp_cnt++; if (timeout_out !== 1'b1) begin err_cnt++; $display("FAIL to_flag: got %b want 1", timeout_out); end
    cmp_cnt++; if (pulses !== 2) begin err_cnt++; $display("FAIL to_requests: got %0d want 2", pulses); end
    // 255 wait cycles, then FETCH and ISSUE for idx 1
    cmp_cnt++; if (pulse_cyc[1] - pulse_cyc[0] !== 257) begin err_cnt++; $display("FAIL to_gap: got %0d want 257", pulse_cyc[1] - pulse_cyc[0]); end
    cmp_cnt++; if (obs_edge[1] !== edge_model[1]) begin err_cnt++; $display("FAIL to_edge1: got %h want %h", obs_edge[1], edge_model[1]); end
    cmp_cnt++; if (collision_out !== 1'b0 || x_new_out !== 8'(-4) || y_new_out !== 8'(2)) begin err_cnt++; $display("FAIL to_result: got c=%b (%0d,%0d) want 0 (-4,2)", collision_out, x_new_out, y_new_out); end
    @(negedge clk_in);
  endtask

  task automatic test_busy_rules();
    bit ok;
    int ov_seen;
    logic signed [P-1:0] x_seen;
    for (int i = 0; i < ME; i++) mode[i] = 0;
    pulses = 0;
    ov_seen = 0;
    x_seen = '0;
    start_scan(2, 30, 30, 0, 0, 4, 4);
    @(negedge clk_in);
    // write and a second start while busy: both must be dropped
    edge_we_in = 1'b1;
    edge_addr_in = '0;
    {edge_v1_in, edge_v2_in} = 32'hDEADBEEF;
    pos_x_in = 8'(-50);
    start_in = 1'b1;
    @(negedge clk_in);
    edge_we_in = 1'b0;
    start_in = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (output_valid === 1'b1) begin
        ov_seen++;
        x_seen = x_new_out;
      end
      @(negedge clk_in);
    end
    cmp_cnt++; if (ov_seen !== 1) begin err_cnt++; $display("FAIL busy_one_result: got %0d want 1", ov_seen); end
    cmp_cnt++; if (x_seen !== 8'(34)) begin err_cnt++; $display("FAIL busy_first_req: got %0d want 34", x_seen); end
    pulses = 0;
    start_scan(1, 0, 0, 0, 0, 0, 0);
    wait_done(100, ok);
    cmp_cnt++; if (!ok) begin err_cnt++; $display("FAIL busy_rescan_done: got no output_valid want one within 100 cycles"); end
    cmp_cnt++; if (obs_edge[0] !== edge_model[0]) begin err_cnt++; $display("FAIL busy_ram_kept: got %h want %h", obs_edge[0], edge_model[0]); end
    @(negedge clk_in);
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int ov_seen;
    int guard;
    for (int i = 0; i < ME; i++) mode[i] = 0;
    mode[0] = 2;
    pulses = 0;
    ov_seen = 0;
    start_scan(1, 9, 9, 3, 3, 1, 1);
    guard = 0;
    while (pulses == 0 && guard < 50) begin
      @(negedge clk_in);
      guard++;
    end
    cmp_cnt++; if (pulses !== 1) begin err_cnt++; $display("FAIL rst_issue: got %0d requests want 1", pulses); end
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    coll_valid_in = 1'b1;
    coll_collision_in = 1'b1;
    coll_x_new_in = 8'(4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (output_valid === 1'b1) ov_seen++;
    end
    cmp_cnt++; if (ov_seen !== 0) begin err_cnt++; $display("FAIL rst_no_result: got %0d output_valid pulses want 0", ov_seen); end
    cmp_cnt++; if (busy_out !== 1'b0 || coll_valid_out !== 1'b0) begin err_cnt++; $display("FAIL rst_idle: got busy=%b cv=%b want 0,0", busy_out, coll_valid_out); end
    cmp_cnt++; if ({x_new_out, y_new_out, vx_new_out, vy_new_out, collision_out, edge_idx_out, timeout_out} !== '0) begin err_cnt++; $display("FAIL rst_results_zero: got x=%0d y=%0d c=%b idx=%0d t=%b want all 0", x_new_out, y_new_out, collision_out, edge_idx_out, timeout_out); end
    cmp_cnt++; if ({coll_v1_out, coll_v2_out, coll_pos_x_out, coll_vel_x_out, coll_dx_out} !== '0) begin err_cnt++; $display("FAIL rst_req_zero: got v1=%h px=%0d want 0", coll_v1_out, coll_pos_x_out); end
    // RAM contents survive reset
    mode[0] = 0;
    pulses = 0;
    start_scan(1, 0, 0, 0, 0, 0, 0);
    wait_done(100, ok);
    cmp_cnt++; if (!ok || obs_edge[0] !== edge_model[0]) begin err_cnt++; $display("FAIL rst_ram_kept: got done=%b edge=%h want 1 %h", ok, obs_edge[0], edge_model[0]); end
    @(negedge clk_in);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < ME; i++) mode[i] = 0;
    test_reset();
    test_zero_edges();
    test_hit();
    test_wrap_16();
    test_timeout();
    test_busy_rules();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion want finish before 200000 ns");
    $fatal(1, "bench time limit");
  end

endmodule
